// File: rtl/debounce_pkg.sv
// Shared types and helpers for the pin debouncer: FSM state encoding and the
// minimum legal stability window.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } db_state_t;

  localparam int DB_MIN_STABLE = 2;

  // Resting state for a given debounced level.
  function automatic db_state_t idle_state(input logic lvl);
    return lvl ? IDLE_HIGH : IDLE_LOW;
  endfunction

  // Counting state entered when the synchronized input disagrees with lvl.
  function automatic db_state_t check_state(input logic lvl);
    return lvl ? CHECK_LOW : CHECK_HIGH;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin; reusable for any input.
// Only the second stage may be observed by downstream logic.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Synchronizes and debounces one asynchronous input, producing a clean level
// and single-cycle rise/fall pulses. The FSM state is exposed for observation.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 4,
  parameter logic INIT          = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      din,
  output logic      level,
  output logic      rise,
  output logic      fall,
  output logic      busy,
  output db_state_t state
);

  localparam int        CNT_W       = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam db_state_t RESET_STATE = idle_state(INIT);

  if (STABLE_CYCLES < DB_MIN_STABLE) begin : g_bad_stable
    $error("debounce_edge: STABLE_CYCLES must be at least %0d", DB_MIN_STABLE);
  end

  logic             s2;
  logic [CNT_W-1:0] cnt;

  sync_2ff #(
    .RST_VAL(INIT)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (s2)
  );

  // A candidate change must be seen on STABLE_CYCLES consecutive edges; any
  // edge agreeing with the current level discards the count silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
      cnt   <= '0;
      level <= INIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= s2;
          cnt   <= '0;
          rise  <= s2;
          fall  <= ~s2;
          busy  <= 1'b0;
          state <= idle_state(s2);
        end else begin
          cnt   <= cnt + CNT_W'(1);
          busy  <= 1'b1;
          state <= check_state(level);
        end
      end else begin
        cnt   <= '0;
        busy  <= 1'b0;
        state <= idle_state(level);
      end
    end
  end

  a_pulse_exclusive : assert property (@(posedge clk) !(rise && fall));
  a_cnt_bounded     : assert property (@(posedge clk) cnt <= CNT_LAST);

endmodule
